plot_arbiter: RTL and testbench
===============================

# plot_arbiter

Parametrised N-channel pixel-write arbiter between the game's drawing engines (snake, food, score overlay) and the single VGA adapter write port (`VGA_x`/`VGA_y`/`VGA_color`/`VGA_write`) inside `vga_demo`. It replaces the single hard-wired snake plot path with fair round-robin sharing. It also adds an off-screen clipping filter with a drop counter, and a hardware full-screen clear sweep that the game FSM can trigger.

## Interface
Parameters:
- `NCH`, 2, number of requesting channels (1..8)
- `XW`, 8, x coordinate width
- `YW`, 7, y coordinate width
- `CW`, 9, colour width
- `XMAX`, 159, largest on-screen x
- `YMAX`, 119, largest on-screen y

Ports:
- `CLOCK_50`  in  1  system clock; all state on its rising edge
- `resetn`  in  1  asynchronous active-low reset
- `ch_valid`  in  NCH  per-channel pixel request
- `ch_ready`  out  NCH  per-channel grant; a transfer occurs on valid & ready
- `ch_x`  in  NCH*XW  packed x; channel i occupies bits [i*XW +: XW]
- `ch_y`  in  NCH*YW  packed y, same packing
- `ch_color`  in  NCH*CW  packed colour, same packing
- `clear_req`  in  1  single-cycle pulse; starts a full-screen clear
- `clear_color`  in  CW  fill colour, sampled when `clear_req` is accepted
- `clear_done`  out  1  one-cycle pulse when the sweep finishes
- `busy_clear`  out  1  high while the sweep is running
- `drop_count`  out  16  count of clipped pixels, saturating
- `VGA_x`  out  XW  registered write x
- `VGA_y`  out  YW  registered write y
- `VGA_color`  out  CW  registered write colour
- `VGA_write`  out  1  registered write strobe; one pixel per cycle

## Operation
- States are ARB and CLEAR. Reset enters ARB.
- **ARB arbitration.** `ch_ready` is combinational from `ch_valid` and the registered pointer `last`.
  - The grant goes to the first valid channel found scanning `last+1`, `last+2`, … modulo NCH.
  - At most one ready bit is high. With no valid input, all ready bits are low.
  - `ready` is never asserted without `valid`.
  - On a transfer, `last` is updated to the granted index.
- **Clipping.** An accepted pixel with x > XMAX or y > YMAX is consumed but not written: `VGA_write` stays 0 for that slot.
  - `drop_count` increments on each clipped pixel and saturates at 16'hFFFF.
- **Entering CLEAR.** If `clear_req` is high in ARB, it takes priority over channels.
  - No grant is issued that cycle.
  - The FSM latches `clear_color` and enters CLEAR with sweep counters x=0, y=0.
- **CLEAR sweep.**
  - All `ch_ready` are low and `busy_clear`=1.
  - Each cycle writes (x, y, clear colour), scanning x fastest from 0..XMAX, then y from 0..YMAX.
  - The sweep takes exactly (XMAX+1)*(YMAX+1) write cycles (19200 at the defaults).
  - After the final pixel (XMAX, YMAX) is issued, the FSM returns to ARB and pulses `clear_done` for one cycle.
  - `clear_req` pulses during CLEAR are ignored and are not queued.
  - `last` is unchanged by a sweep.
- **Width rules.**
  - Sweep counters are XW/YW wide and compare against XMAX/YMAX, never against overflow.
  - The clip compare is unsigned.

## Timing
- **Reset values.**
  - Asynchronous reset, effective immediately, including mid-sweep.
  - `VGA_x`, `VGA_y`, `VGA_color`, `VGA_write`, `clear_done`, `busy_clear` and `drop_count` all reset to 0.
  - `last` resets to NCH-1, so channel 0 wins first. State resets to ARB.
  - A sweep interrupted by reset is abandoned and never completes `clear_done`.
- **Channel latency.** A transfer accepted in cycle n appears on `VGA_*` with `VGA_write`=1 in cycle n+1, for exactly one cycle.
- **Sustained throughput.** One transfer per cycle. Channels holding valid are served in strict rotation.
- **Sweep timing.**
  - `clear_req` in cycle n gives `busy_clear`=1 from n+1.
  - The first sweep write (0,0) appears at n+1 and the last at n+19200.
  - In cycle n+19200, `busy_clear`=0 and `clear_done`=1, and arbitration resumes in that cycle.
- **Simultaneous events.**
  - `clear_req` together with valid channels: no grant, and the channels keep waiting.
  - A clip and an on-screen write never coincide, since there is one transfer per cycle.
- **Output gaps.** `VGA_x`/`VGA_y`/`VGA_color` hold their last value when `VGA_write`=0.

## Test plan
- **Reset and idle.** Reset, then idle with all `ch_valid`=0 → all outputs 0 and `ch_ready`=0 for 10 cycles.
- **Round-robin fairness.** NCH=3, all valid held high for 6 cycles → grant order 0,1,2,0,1,2. Pixel from cycle n is seen on `VGA_*` at n+1 with `VGA_write`=1 every cycle.
- **Clipping.** Channel 0 sends (160,5), (5,120), then (159,119) → first two are consumed with no write, `drop_count`=2; third is written at (159,119).
- **Clear sweep.** `clear_req` with `clear_color`=9'h1FF while channel 1 is valid → `ch_ready`=0 for 19200 cycles.
  - Writes cover (0,0)..(159,119) in raster order, colour 1FF.
  - `clear_done` pulses once; channel 1 is granted in the same cycle.
- **Reset mid-sweep.** Assert `resetn`=0 at sweep pixel 5000 → outputs 0 immediately, no `clear_done`. After release, channel 0 is granted first.
- **Drop counter saturation.** Force 65540 clipped pixels → `drop_count` holds at 16'hFFFF.

Source files
------------

// File: rtl/plot_arbiter.sv
// Round-robin pixel-write arbiter feeding the single VGA adapter write port,
// with off-screen clipping, a saturating drop counter and a full-screen clear sweep.
`timescale 1ns/1ps

module plot_arbiter #(
  parameter int NCH  = 2,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 9,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH*XW-1:0] ch_x,
  input  logic [NCH*YW-1:0] ch_y,
  input  logic [NCH*CW-1:0] ch_color,
  input  logic              clear_req,
  input  logic [CW-1:0]     clear_color,
  output logic              clear_done,
  output logic              busy_clear,
  output logic [15:0]       drop_count,
  output logic [XW-1:0]     VGA_x,
  output logic [YW-1:0]     VGA_y,
  output logic [CW-1:0]     VGA_color,
  output logic              VGA_write,
  output logic              fsm_state
);

  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [XW-1:0] XMAX_V = XW'(XMAX);
  localparam logic [YW-1:0] YMAX_V = YW'(YMAX);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   last;
  logic [LW-1:0]   grant_idx;
  logic            found;
  logic            transfer;
  logic [XW-1:0]   sel_x;
  logic [YW-1:0]   sel_y;
  logic [CW-1:0]   sel_color;
  logic            clip;
  logic [XW-1:0]   sx;
  logic [YW-1:0]   sy;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic            sweep_last;
  logic [CW-1:0]   clr_color;

  assign fsm_state = state;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int cand;
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(last) + k) % NCH;
      if (!found && ch_valid[cand[LW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[LW-1:0];
      end
    end
  end

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(grant_idx) == i) begin
        sel_x     = ch_x[i*XW +: XW];
        sel_y     = ch_y[i*YW +: YW];
        sel_color = ch_color[i*CW +: CW];
      end
    end
  end

  assign clip = (sel_x > XMAX_V) || (sel_y > YMAX_V);

  // sx/sy hold the pixel most recently issued by the sweep; nx/ny is its raster successor.
  always_comb begin
    if (sx == XMAX_V) begin
      nx = '0;
      ny = sy + YW'(1);
    end else begin
      nx = sx + XW'(1);
      ny = sy;
    end
    sweep_last = (nx == XMAX_V) && (ny == YMAX_V);
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ARB;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (clear_req) state_next = CLEAR;
      CLEAR:   if (sweep_last) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Handshake: a channel transfers on ch_valid & ch_ready in the same cycle;
  // ready is only ever raised for one valid channel, never while clearing or on a clear request.
  always_comb begin
    ch_ready   = '0;
    busy_clear = (state == CLEAR);
    if (state == ARB && !clear_req && found) ch_ready[grant_idx] = 1'b1;
  end

  assign transfer = |ch_ready;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      VGA_x      <= '0;
      VGA_y      <= '0;
      VGA_color  <= '0;
      VGA_write  <= 1'b0;
      clear_done <= 1'b0;
      drop_count <= '0;
      last       <= LW'(NCH - 1);
      sx         <= '0;
      sy         <= '0;
      clr_color  <= '0;
    end else begin
      VGA_write  <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ARB: begin
          if (clear_req) begin
            clr_color <= clear_color;
            sx        <= '0;
            sy        <= '0;
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= clear_color;
            VGA_write <= 1'b1;
          end else if (transfer) begin
            last <= grant_idx;
            if (clip) begin
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else begin
              VGA_x     <= sel_x;
              VGA_y     <= sel_y;
              VGA_color <= sel_color;
              VGA_write <= 1'b1;
            end
          end
        end
        CLEAR: begin
          sx        <= nx;
          sy        <= ny;
          VGA_x     <= nx;
          VGA_y     <= ny;
          VGA_color <= clr_color;
          VGA_write <= 1'b1;
          if (sweep_last) clear_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter (NCH=3): reset/idle, round-robin, clipping,
// clear sweep, reset mid-sweep and drop counter saturation.
`timescale 1ns/1ps

module tb_plot_arbiter;
  localparam int NCH = 3;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 9;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*XW-1:0] ch_x;
  logic [NCH*YW-1:0] ch_y;
  logic [NCH*CW-1:0] ch_color;
  logic              clear_req;
  logic [CW-1:0]     clear_color;
  logic              clear_done;
  logic              busy_clear;
  logic [15:0]       drop_count;
  logic [XW-1:0]     VGA_x;
  logic [YW-1:0]     VGA_y;
  logic [CW-1:0]     VGA_color;
  logic              VGA_write;
  logic              fsm_state;
  logic [24:0]       vga_obs;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  plot_arbiter #(.NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .XMAX(159), .YMAX(119)) dut (
    .CLOCK_50(clk), .resetn(resetn),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_x(ch_x), .ch_y(ch_y), .ch_color(ch_color),
    .clear_req(clear_req), .clear_color(clear_color),
    .clear_done(clear_done), .busy_clear(busy_clear), .drop_count(drop_count),
    .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
    .fsm_state(fsm_state)
  );

  assign vga_obs = {VGA_write, VGA_x, VGA_y, VGA_color};

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [24:0] pix(input logic w, input logic [7:0] x,
                                      input logic [6:0] y, input logic [8:0] c);
    return {w, x, y, c};
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic [7:0] x,
                        input logic [6:0] y, input logic [8:0] c);
    ch_valid[i]        = v;
    ch_x[i*XW +: XW]   = x;
    ch_y[i*YW +: YW]   = y;
    ch_color[i*CW +: CW] = c;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed empty queue expected an entry", tag);
    end else begin
      check(tag, 32'(vga_obs), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    resetn      = 1'b0;
    ch_valid    = '0;
    ch_x        = '0;
    ch_y        = '0;
    ch_color    = '0;
    clear_req   = 1'b0;
    clear_color = '0;

    // reset and idle
    repeat (3) cyc();
    settle();
    check("rst_vga", 32'(vga_obs), 32'd0);
    check("rst_ctl", 32'({ch_ready, busy_clear, clear_done, fsm_state}), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      settle();
      check("idle_vga", 32'(vga_obs), 32'd0);
      check("idle_ctl", 32'({drop_count, ch_ready, busy_clear, clear_done}), 32'd0);
    end

    // round robin with all three channels held valid
    exp_q.push_back(25'd0);
    for (int c = 0; c < 6; c++) begin
      cyc();
      for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 8'(10 + i), 7'(20 + i), 9'(100 + i));
      settle();
      check("rr_ready", 32'(ch_ready), 32'(1 << (c % 3)));
      sb_check("rr_vga");
      exp_q.push_back(pix(1'b1, 8'(10 + c % 3), 7'(20 + c % 3), 9'(100 + c % 3)));
    end
    cyc();
    ch_valid = '0;
    settle();
    check("rr_idle_ready", 32'(ch_ready), 32'd0);
    sb_check("rr_vga_tail");
    exp_q.push_back(pix(1'b0, 8'd12, 7'd22, 9'd102));
    cyc();
    settle();
    sb_check("rr_hold");

    // clipping on channel 0
    cyc();
    set_ch(0, 1'b1, 8'd160, 7'd5, 9'h011);
    settle();
    check("clip0_ready", 32'(ch_ready), 32'b001);
    cyc();
    set_ch(0, 1'b1, 8'd5, 7'd120, 9'h022);
    settle();
    check("clip1_ready", 32'(ch_ready), 32'b001);
    check("clip0_vga", 32'(vga_obs), 32'(pix(1'b0, 8'd12, 7'd22, 9'd102)));
    check("clip0_drop", 32'(drop_count), 32'd1);
    cyc();
    set_ch(0, 1'b1, 8'd159, 7'd119, 9'h0AA);
    settle();
    check("clip1_vga", 32'(vga_obs), 32'(pix(1'b0, 8'd12, 7'd22, 9'd102)));
    check("clip1_drop", 32'(drop_count), 32'd2);
    cyc();
    ch_valid = '0;
    settle();
    check("edge_vga", 32'(vga_obs), 32'(pix(1'b1, 8'd159, 7'd119, 9'h0AA)));
    check("edge_drop", 32'(drop_count), 32'd2);

    // clear sweep while channel 1 waits; a second request mid-sweep is ignored
    cyc();
    set_ch(1, 1'b1, 8'd30, 7'd40, 9'h055);
    clear_req   = 1'b1;
    clear_color = 9'h1FF;
    settle();
    check("clr_req_ctl", 32'({ch_ready, busy_clear, clear_done}), 32'd0);
    for (int k = 0; k < 19199; k++) begin
      cyc();
      clear_req   = (k == 100);
      clear_color = 9'h000;
      settle();
      check("sweep_px", 32'(vga_obs), 32'(pix(1'b1, 8'(k % 160), 7'(k / 160), 9'h1FF)));
      check("sweep_ctl", 32'({ch_ready, busy_clear, clear_done, fsm_state}), 32'b000101);
    end
    cyc();
    clear_req = 1'b0;
    settle();
    check("sweep_last", 32'(vga_obs), 32'(pix(1'b1, 8'd159, 7'd119, 9'h1FF)));
    check("done_ctl", 32'({ch_ready, busy_clear, clear_done, fsm_state}), 32'b010010);
    cyc();
    ch_valid = '0;
    settle();
    check("post_clear_vga", 32'(vga_obs), 32'(pix(1'b1, 8'd30, 7'd40, 9'h055)));
    check("post_clear_ctl", 32'({ch_ready, busy_clear, clear_done, fsm_state}), 32'd0);
    cyc();
    settle();
    check("no_resweep", 32'({busy_clear, clear_done, VGA_write}), 32'd0);

    // reset at sweep pixel 5000
    cyc();
    clear_req   = 1'b1;
    clear_color = 9'h0F0;
    settle();
    for (int k = 0; k <= 5000; k++) begin
      cyc();
      clear_req = 1'b0;
      settle();
    end
    check("mid_px5000", 32'(vga_obs), 32'(pix(1'b1, 8'd40, 7'd31, 9'h0F0)));
    resetn = 1'b0;
    #1;
    check("mid_rst_vga", 32'(vga_obs), 32'd0);
    check("mid_rst_ctl", 32'({drop_count, busy_clear, clear_done, fsm_state}), 32'd0);
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 8'(50 + i), 7'(60 + i), 9'(9'h100 + i));
    cyc();
    cyc();
    resetn = 1'b1;
    settle();
    check("rst_first_grant", 32'(ch_ready), 32'b001);
    check("rst_vga_idle", 32'(vga_obs), 32'd0);
    cyc();
    settle();
    check("rst_rr1_ready", 32'(ch_ready), 32'b010);
    check("rst_rr1_vga", 32'(vga_obs), 32'(pix(1'b1, 8'd50, 7'd60, 9'h100)));
    cyc();
    ch_valid = '0;
    settle();
    check("rst_rr2_vga", 32'(vga_obs), 32'(pix(1'b1, 8'd51, 7'd61, 9'h101)));
    check("rst_no_done", 32'({busy_clear, clear_done, fsm_state}), 32'd0);

    // drop counter saturation with a continuously clipped channel 0
    for (int j = 0; j <= 65540; j++) begin
      cyc();
      if (j == 0) set_ch(0, 1'b1, 8'd200, 7'd0, 9'h000);
      if (j == 65540) ch_valid = '0;
      settle();
      check("sat", 32'({VGA_write, drop_count}), 32'((j > 65535) ? 65535 : j));
    end
    cyc();
    settle();
    check("sat_hold", 32'(drop_count), 32'hFFFF);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
